// File: rtl/rgbw_frame_pkg.sv
// Shared definitions for the RGBW control frame link: sync byte, payload
// layout and byte-index constants (also used on the receiver side), and the
// frame FSM state encoding.
package rgbw_frame_pkg;

  localparam logic [7:0]  SYNC_BYTE     = 8'h55;
  localparam int unsigned PAYLOAD_BYTES = 7;

  // Payload byte order on the wire, after the sync byte.
  localparam logic [2:0] IDX_LINT      = 3'd0;
  localparam logic [2:0] IDX_COLOR_IDX = 3'd1;
  localparam logic [2:0] IDX_RED       = 3'd2;
  localparam logic [2:0] IDX_GREEN     = 3'd3;
  localparam logic [2:0] IDX_BLUE      = 3'd4;
  localparam logic [2:0] IDX_WHITE     = 3'd5;
  localparam logic [2:0] IDX_MODE      = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    GAP,
    TRAIL
  } frame_state_t;

  typedef struct packed {
    logic [7:0] lint;
    logic [7:0] color_idx;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [7:0] white;
    logic [7:0] mode;
  } rgbw_payload_t;

  // Payload byte by wire index.
  function automatic logic [7:0] payload_byte(rgbw_payload_t p, logic [2:0] idx);
    case (idx)
      IDX_LINT:      payload_byte = p.lint;
      IDX_COLOR_IDX: payload_byte = p.color_idx;
      IDX_RED:       payload_byte = p.red;
      IDX_GREEN:     payload_byte = p.green;
      IDX_BLUE:      payload_byte = p.blue;
      IDX_WHITE:     payload_byte = p.white;
      IDX_MODE:      payload_byte = p.mode;
      default:       payload_byte = p.mode;
    endcase
  endfunction

  // Frame checksum: XOR of the payload bytes (sync byte excluded).
  function automatic logic [7:0] payload_xor(rgbw_payload_t p);
    payload_xor = p.lint ^ p.color_idx ^ p.red ^ p.green ^ p.blue ^ p.white ^ p.mode;
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter, MSB first. Owns the sclk divider, bit counter,
// sclk and mosi.
//   load/byte_in : preload the shift register (mosi shows byte_in[7] next cycle)
//   go           : start the 8-bit sequence; sclk rises on the same edge
//   byte_done_c  : high in the last low cycle of bit 0 (byte finished)
//   sclk, mosi   : registered SPI outputs
module spi_byte_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       go,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done_c
);

  localparam int unsigned DIV_W    = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  // mosi is the shift register MSB, so it is a flop output.
  assign mosi        = shreg[7];
  assign byte_done_c = active && !sclk && (bit_cnt == 3'd0) && (div_cnt == DIV_LAST);

  // Half-period divider; mosi shifts on falling edges except after bit 0,
  // where the next byte is loaded at the end of the low phase instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (load) shreg <= byte_in;
      if (!active) begin
        if (go) begin
          active  <= 1'b1;
          sclk    <= 1'b1;
          div_cnt <= '0;
          bit_cnt <= 3'd7;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
        if (sclk) begin
          sclk <= 1'b0;
          if (bit_cnt != 3'd0) shreg <= {shreg[6:0], 1'b0};
        end else if (bit_cnt == 3'd0) begin
          active <= 1'b0;
        end else begin
          sclk    <= 1'b1;
          bit_cnt <= bit_cnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/rgbw_frame_sender.sv
// RGBW control frame sender (SPI master, mode 0, MSB first).
// Frame: 0x55, lint, color_idx, red, green, blue, white, mode
// [, checksum when RGBW_FRAME_CHECKSUM_EN is defined].
//   clk, reset   : clock, async active-high reset
//   send         : start request, accepted when busy=0
//   lint..mode   : payload, snapshotted in the accept cycle
//   cs_n/sclk/mosi : SPI outputs
//   busy, done   : frame in progress / one-cycle completion pulse
module rgbw_frame_sender #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] lint,
  input  logic [7:0] color_idx,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic [7:0] white,
  input  logic [7:0] mode,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done
);
  import rgbw_frame_pkg::*;

`ifdef RGBW_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES + 2;
`else
  localparam int unsigned FRAME_BYTES = PAYLOAD_BYTES + 1;
`endif
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);

  frame_state_t     state, state_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d, next_idx;
  logic [7:0]       phase_cnt, phase_d;
  logic             cs_n_d, busy_d, done_d;
  logic             snap_en, tx_load, tx_go, byte_done_c;
  logic [7:0]       tx_byte, next_byte, checksum;
  rgbw_payload_t    snap;

`ifdef RGBW_FRAME_CHECKSUM_EN
  assign checksum = payload_xor(snap);
`else
  assign checksum = 8'h00;
`endif

  // Byte following the one currently on the wire (index >= 1).
  always_comb begin
    next_idx = byte_cnt + CNT_W'(1);
    if (next_idx <= CNT_W'(PAYLOAD_BYTES)) next_byte = payload_byte(snap, 3'(next_idx - CNT_W'(1)));
    else                                    next_byte = checksum;
  end

  // Frame FSM next state and control strobes.
  always_comb begin
    state_d    = state;
    cs_n_d     = cs_n;
    busy_d     = busy;
    done_d     = 1'b0;
    byte_cnt_d = byte_cnt;
    phase_d    = phase_cnt;
    snap_en    = 1'b0;
    tx_load    = 1'b0;
    tx_byte    = 8'h00;
    tx_go      = 1'b0;
    case (state)
      IDLE: begin
        if (send) begin
          snap_en    = 1'b1;
          tx_load    = 1'b1;
          tx_byte    = SYNC_BYTE;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          phase_d    = '0;
          state_d    = LEAD;
        end
      end
      LEAD, GAP: begin
        if (phase_cnt == DIV_LAST) begin
          tx_go   = 1'b1;
          phase_d = '0;
          state_d = SHIFT;
        end else begin
          phase_d = phase_cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (byte_done_c) begin
          phase_d = '0;
          if (byte_cnt == LAST_BYTE) begin
            state_d = TRAIL;
          end else begin
            byte_cnt_d = next_idx;
            tx_load    = 1'b1;
            tx_byte    = next_byte;
            state_d    = GAP;
          end
        end
      end
      TRAIL: begin
        if (phase_cnt == DIV_LAST) begin
          cs_n_d     = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          tx_load    = 1'b1;
          tx_byte    = 8'h00;
          byte_cnt_d = '0;
          phase_d    = '0;
          state_d    = IDLE;
        end else begin
          phase_d = phase_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, registered outputs and payload snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_cnt  <= '0;
      phase_cnt <= '0;
      snap      <= '0;
    end else begin
      state     <= state_d;
      cs_n      <= cs_n_d;
      busy      <= busy_d;
      done      <= done_d;
      byte_cnt  <= byte_cnt_d;
      phase_cnt <= phase_d;
      if (snap_en) snap <= '{lint, color_idx, red, green, blue, white, mode};
    end
  end

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk         (clk),
    .reset       (reset),
    .load        (tx_load),
    .byte_in     (tx_byte),
    .go          (tx_go),
    .sclk        (sclk),
    .mosi        (mosi),
    .byte_done_c (byte_done_c)
  );

endmodule

// File: tb/tb_rgbw_frame_sender.sv
// Self-checking bench for rgbw_frame_sender (CLK_DIV=4). Honours
// RGBW_FRAME_CHECKSUM_EN for the expected frame length.
`timescale 1ns/1ps
module tb_rgbw_frame_sender;

  localparam int CLK_DIV = 4;
`ifdef RGBW_FRAME_CHECKSUM_EN
  localparam int NB         = 9;
  localparam int EXP_CS_LEN = 616;
`else
  localparam int NB         = 8;
  localparam int EXP_CS_LEN = 548;
`endif

  logic clk = 1'b0;
  logic reset, send;
  logic [7:0] lint, color_idx, red, green, blue, white, mode;
  logic cs_n, sclk, mosi, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // SPI monitor state
  logic [7:0] mon_bytes[$];
  int cs_low_cnt = 0, last_cs_len = 0, done_cnt = 0, viol_cnt = 0;
  int bitn = 0, hi_run = 0, mosi_stable = 0;
  logic [7:0] sh = 8'h00;
  logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs_n = 1'b1;

  logic [7:0] exp_pay [7];

  always #5 clk = ~clk;

  rgbw_frame_sender #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .send(send),
    .lint(lint), .color_idx(color_idx), .red(red), .green(green),
    .blue(blue), .white(white), .mode(mode),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .busy(busy), .done(done)
  );

  // Decodes mosi on sclk rising edges and records protocol violations.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      bitn = 0; cs_low_cnt = 0; hi_run = 0; mosi_stable = 0;
      prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs_n = 1'b1;
    end else begin
      if (!cs_n) cs_low_cnt++;
      else if (!prev_cs_n) begin last_cs_len = cs_low_cnt; cs_low_cnt = 0; end
      if (done) begin
        done_cnt++;
        if (!(cs_n && !prev_cs_n)) viol_cnt++;
      end
      if (sclk && cs_n) viol_cnt++;
      if (sclk && prev_sclk && mosi !== prev_mosi) viol_cnt++;
      if (mosi !== prev_mosi) mosi_stable = 1; else mosi_stable++;
      if (sclk) hi_run++;
      else if (prev_sclk) begin
        if (hi_run != CLK_DIV) viol_cnt++;
        hi_run = 0;
      end
      if (cs_n) bitn = 0;
      else if (sclk && !prev_sclk) begin
        if (mosi_stable < CLK_DIV + 1) viol_cnt++;
        sh = {sh[6:0], mosi};
        bitn++;
        if (bitn == 8) begin mon_bytes.push_back(sh); bitn = 0; end
      end
      prev_sclk = sclk; prev_mosi = mosi; prev_cs_n = cs_n;
    end
  end

  function automatic logic [7:0] exp_byte(int i);
    logic [7:0] x;
    x = 8'h00;
    if (i == 0) return 8'h55;
    if (i <= 7) return exp_pay[i-1];
    for (int k = 0; k < 7; k++) x ^= exp_pay[k];
    return x;
  endfunction

  task automatic apply_payload();
    lint = exp_pay[0]; color_idx = exp_pay[1]; red = exp_pay[2]; green = exp_pay[3];
    blue = exp_pay[4]; white = exp_pay[5]; mode = exp_pay[6];
  endtask

  task automatic clear_monitor();
    mon_bytes.delete(); done_cnt = 0; viol_cnt = 0; last_cs_len = 0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; send = 1'b0;
    exp_pay = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    apply_payload();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 10000", {cs_n, sclk, mosi, busy, done});
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
        n_fail++; $display("FAIL idle_outputs cycle %0d: got %b expected 10000", i, {cs_n, sclk, mosi, busy, done});
      end
    end
  endtask

  task automatic test_single_frame();
    bit seen;
    exp_pay = '{8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA5};
    apply_payload();
    clear_monitor();
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
    n_checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL accept_latency: cs_n=%b busy=%b expected cs_n=0 busy=1", cs_n, busy);
    end
    wait_done(2000, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL single_done_timeout: done not seen, expected within 2000 cycles"); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (mon_bytes.size() !== NB) begin
      n_fail++; $display("FAIL single_byte_count: got %0d expected %0d", mon_bytes.size(), NB);
    end
    for (int i = 0; i < NB && i < mon_bytes.size(); i++) begin
      n_checks++;
      if (mon_bytes[i] !== exp_byte(i)) begin
        n_fail++; $display("FAIL single_byte[%0d]: got %h expected %h", i, mon_bytes[i], exp_byte(i));
      end
    end
`ifdef RGBW_FRAME_CHECKSUM_EN
    n_checks++;
    if (mon_bytes.size() < 9 || mon_bytes[8] !== 8'h52) begin
      n_fail++; $display("FAIL checksum_byte: got %h expected 52", mon_bytes.size() >= 9 ? mon_bytes[8] : 8'hxx);
    end
`endif
    n_checks++;
    if (last_cs_len !== EXP_CS_LEN) begin
      n_fail++; $display("FAIL single_cs_len: got %0d expected %0d", last_cs_len, EXP_CS_LEN);
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
    n_checks++;
    if (viol_cnt !== 0) begin n_fail++; $display("FAIL single_protocol: got %0d violations expected 0", viol_cnt); end
    n_checks++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
      n_fail++; $display("FAIL single_idle_after: got %b expected 10000", {cs_n, sclk, mosi, busy, done});
    end
  endtask

  task automatic test_ignore_send();
    bit seen;
    exp_pay = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h5A};
    apply_payload();
    clear_monitor();
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
    repeat (98) @(negedge clk);
    send = 1'b1;
    lint = 8'hEE; color_idx = 8'hEE; red = 8'hEE; green = 8'hEE;
    blue = 8'hEE; white = 8'hEE; mode = 8'hEE;
    @(negedge clk) send = 1'b0;
    wait_done(2000, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL ignore_done_timeout: done not seen, expected within 2000 cycles"); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (done_cnt !== 1 || mon_bytes.size() !== NB) begin
      n_fail++; $display("FAIL ignore_one_frame: got %0d done %0d bytes expected 1 done %0d bytes", done_cnt, mon_bytes.size(), NB);
    end
    for (int i = 0; i < NB && i < mon_bytes.size(); i++) begin
      n_checks++;
      if (mon_bytes[i] !== exp_byte(i)) begin
        n_fail++; $display("FAIL ignore_byte[%0d]: got %h expected %h", i, mon_bytes[i], exp_byte(i));
      end
    end
    n_checks++;
    if (last_cs_len !== EXP_CS_LEN || viol_cnt !== 0 || cs_n !== 1'b1) begin
      n_fail++; $display("FAIL ignore_timing: cs_len=%0d viol=%0d cs_n=%b expected %0d 0 1", last_cs_len, viol_cnt, cs_n, EXP_CS_LEN);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    exp_pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07};
    apply_payload();
    clear_monitor();
    @(negedge clk) send = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(2000, seen);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL b2b_done_timeout frame %0d: done not seen", k); end
      @(negedge clk);
      n_checks++;
      if (cs_n !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_restart frame %0d: cs_n=%b busy=%b expected 0 1", k + 1, cs_n, busy);
      end
    end
    send = 1'b0;
    wait_done(2000, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_last_done_timeout: done not seen"); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (done_cnt !== 4 || mon_bytes.size() !== 4 * NB) begin
      n_fail++; $display("FAIL b2b_counts: got %0d done %0d bytes expected 4 done %0d bytes", done_cnt, mon_bytes.size(), 4 * NB);
    end
    for (int i = 0; i < 4 * NB && i < mon_bytes.size(); i++) begin
      n_checks++;
      if (mon_bytes[i] !== exp_byte(i % NB)) begin
        n_fail++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, mon_bytes[i], exp_byte(i % NB));
      end
    end
    n_checks++;
    if (last_cs_len !== EXP_CS_LEN || viol_cnt !== 0) begin
      n_fail++; $display("FAIL b2b_timing: cs_len=%0d viol=%0d expected %0d 0", last_cs_len, viol_cnt, EXP_CS_LEN);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    int guard;
    exp_pay = '{8'h13, 8'h57, 8'h9B, 8'hDF, 8'h24, 8'h68, 8'hAC};
    apply_payload();
    clear_monitor();
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
    guard = 0;
    while (mon_bytes.size() < 3 && guard < 1000) begin @(negedge clk); guard++; end
    n_checks++;
    if (mon_bytes.size() < 3) begin n_fail++; $display("FAIL midreset_progress: got %0d bytes expected 3", mon_bytes.size()); end
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
      n_fail++; $display("FAIL midreset_async: got %b expected 10000", {cs_n, sclk, mosi, busy, done});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0 || cs_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_done: done_cnt=%0d cs_n=%b busy=%b expected 0 1 0", done_cnt, cs_n, busy);
    end
    clear_monitor();
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
    wait_done(2000, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midreset_redo_timeout: done not seen"); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (mon_bytes.size() !== NB || last_cs_len !== EXP_CS_LEN || viol_cnt !== 0) begin
      n_fail++; $display("FAIL midreset_redo_frame: bytes=%0d cs_len=%0d viol=%0d expected %0d %0d 0", mon_bytes.size(), last_cs_len, viol_cnt, NB, EXP_CS_LEN);
    end
    for (int i = 0; i < NB && i < mon_bytes.size(); i++) begin
      n_checks++;
      if (mon_bytes[i] !== exp_byte(i)) begin
        n_fail++; $display("FAIL midreset_byte[%0d]: got %h expected %h", i, mon_bytes[i], exp_byte(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_send();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgbw_frame_sender.md
# rgbw_frame_sender

Serialises one RGBW control frame onto an SPI link, bus master, mode 0, MSB first. A frame is sync byte 0x55 followed by lint, color_idx, red, green, blue, white and mode, in the order the RGBW data dispenser unpacks them. The block sits on the host/bridge side of that link. It snapshots the parameter bytes on a start request, drives cs_n/sclk/mosi itself, and reports busy/done to the local controller.

## Interface
- CLK_DIV, 4: clk cycles per sclk half-period; legal range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- send  in  1  start request, sampled each clk; accepted only when busy=0.
- lint, color_idx, red, green, blue, white, mode  in  8 each  frame payload; captured in the accept cycle.
- cs_n  out  1  chip select, active-low, held low for the whole frame.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  serial data, changes only while sclk is low.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: cs_n=1, sclk=0, mosi=0, busy=0, done=0, FSM=IDLE, byte/bit counters=0.
- FSM states: IDLE -> LEAD -> SHIFT -> (GAP -> SHIFT)* -> TRAIL -> IDLE.
- IDLE: on a clk edge with send=1:
  - latch the 7 payload bytes into a holding register;
  - cs_n<=0, busy<=1, mosi<=bit7 of 0x55;
  - go to LEAD.
- LEAD: CLK_DIV cycles with sclk low, then SHIFT.
- SHIFT: 8 bits.
  - Each bit: sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - mosi updates to the next bit on the sclk falling edge.
- After the 8th falling edge:
  - more bytes remain: go to GAP, with mosi already presenting bit7 of the next byte;
  - last byte: go to TRAIL.
- GAP: CLK_DIV cycles with sclk low and cs_n low, then SHIFT.
- TRAIL: CLK_DIV cycles with sclk low, then:
  - cs_n<=1, busy<=0, done<=1 for one cycle, mosi<=0;
  - go to IDLE.
- send while busy=1 is ignored; it is not queued.
- send high in the done cycle is accepted, because busy=0 in that cycle. The next frame then starts with no idle gap beyond that cycle.
- Payload inputs may change freely after the accept edge; the frame always uses the snapshot.
- Byte counter runs 0..N-1, where N=8 (9 with checksum). Bit counter runs 7..0. Divider counter runs 0..CLK_DIV-1 and wraps.
- Reset asserted mid-frame:
  - outputs return to reset values asynchronously;
  - no done pulse is issued;
  - the partial frame is abandoned.

## Timing
- Accept-to-cs_n-low latency: 1 clk (registered outputs).
- cs_n low duration: CLK_DIV*(17N+1) clk cycles.
  - N=8, CLK_DIV=4: 548 cycles.
  - N=9, CLK_DIV=4: 616 cycles.
- done occurs in the same cycle cs_n returns high.
- sclk period: 2*CLK_DIV clk cycles, 50% duty.
- mosi is stable at least CLK_DIV cycles before each rising edge of sclk.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- RGBW_FRAME_CHECKSUM_EN
  - Defined: N=9; a 9th byte is appended, the XOR of the 7 payload bytes (the sync byte is excluded). It is computed from the snapshot.
  - Undefined: N=8; no checksum logic is synthesised.

## Structure
- Shared package rgbw_frame_pkg holds:
  - SYNC_BYTE=8'h55;
  - PAYLOAD_BYTES=7;
  - the FSM state encoding (IDLE, LEAD, SHIFT, GAP, TRAIL);
  - the payload byte index constants, shared with the receiver side.
- Sub-module spi_byte_tx:
  - owns the divider, bit counter, sclk and mosi;
  - interface: load strobe plus byte in; byte_done pulse out.
- The top level owns the frame FSM, the byte counter, the snapshot, and the optional checksum.

## Test plan
- Reset, then idle 20 cycles -> cs_n=1, sclk=0, mosi=0, busy=0, done=0 throughout.
- CLK_DIV=4, send pulse with payload FF,00,12,34,56,78,A5 -> bench SPI monitor decodes 55,FF,00,12,34,56,78,A5; cs_n low for exactly 548 cycles; a single done pulse.
- RGBW_FRAME_CHECKSUM_EN defined, same payload -> 9th byte 0x52; cs_n low for 616 cycles.
- send re-pulsed at cycle 100 of a frame, and payload inputs changed mid-frame -> exactly one frame, carrying the original values.
- send held high continuously -> back-to-back frames, each starting in the cycle after done; every frame is correctly decoded.
- reset pulsed during the 4th byte -> cs_n=1 and sclk=0 asynchronously, no done; the next send produces a complete, correct frame.
